// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port 8K x 32 block RAM between the
// instruction-fetch port (i_*) and the load/store data port (d_*).
// Each grant takes three cycles: IDLE (latch request), ACCESS (drive the
// RAM), RESP (one-cycle ack with the RAM's registered read data).
// Ports: clk, rst (async, active-high); fetch i_req/i_addr -> i_ack/i_rdata;
// data d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata; RAM side m_rd (active-low),
// m_we, m_addr, m_data driven here, m_out returned by the RAM.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on ties;
// otherwise the data port always wins a tie.
module bram_arbiter #(
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int RAM_BUS_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic                      i_ack,
  output logic [RAM_BUS_WIDTH-1:0]  i_rdata,
  input  logic                      d_req,
  input  logic [3:0]                d_we,
  input  logic [31:0]               d_addr,
  input  logic [RAM_BUS_WIDTH-1:0]  d_wdata,
  output logic                      d_ack,
  output logic [RAM_BUS_WIDTH-1:0]  d_rdata,
  output logic                      m_rd,
  output logic [3:0]                m_we,
  output logic [RAM_ADDR_WIDTH-1:0] m_addr,
  output logic [RAM_BUS_WIDTH-1:0]  m_data,
  input  logic [RAM_BUS_WIDTH-1:0]  m_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  // own_d doubles as the last-grant register: 1 = data port
  logic                      own_d;
  logic                      grant_d;
  logic                      any_req;
  logic [3:0]                we_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [RAM_BUS_WIDTH-1:0]  wdata_q;
  logic                      unused_addr_bits;

  assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // on a tie the data port wins only if fetch was granted last
  assign grant_d = d_req & (~i_req | ~own_d);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_d   <= 1'b1;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && any_req) begin
      own_d <= grant_d;
      if (grant_d) begin
        we_q    <= d_we;
        addr_q  <= d_addr[RAM_ADDR_WIDTH+1:2];
        wdata_q <= d_wdata;
      end else begin
        we_q    <= '0;
        addr_q  <= i_addr[RAM_ADDR_WIDTH+1:2];
      end
    end
  end

  always_comb begin
    state_nx = state;
    m_rd     = 1'b1;
    m_we     = '0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ACCESS;
      end
      ACCESS: begin
        // a write keeps the read port idle so m_out is not disturbed
        m_rd     = |we_q;
        m_we     = we_q;
        state_nx = RESP;
      end
      RESP: begin
        i_ack    = ~own_d;
        d_ack    = own_d;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_data  = wdata_q;
  // the RAM holds m_out while m_rd is high, so RESP sees the ACCESS read
  assign i_rdata = m_out;
  assign d_rdata = m_out;

  assign unused_addr_bits = ^{i_addr[31:RAM_ADDR_WIDTH+2], i_addr[1:0],
                              d_addr[31:RAM_ADDR_WIDTH+2], d_addr[1:0]};

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: drives bram_arbiter against a RAM model and checks it
// every cycle against a transaction-level reference model.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        m_rd;
  logic [3:0]  m_we;
  logic [12:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] m_out = '0;

  int total = 0;
  int passed = 0;

  bram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_rd(m_rd), .m_we(m_we), .m_addr(m_addr), .m_data(m_data),
    .m_out(m_out)
  );

  always #5 clk = ~clk;

  // RAM with registered read
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (!m_rd) m_out <= mem[m_addr];
    for (int b = 0; b < 4; b++)
      if (m_we[b]) mem[m_addr][8*b +: 8] <= m_data[8*b +: 8];
  end

  // Reference model: a grant at edge g occupies the RAM on cycle g,
  // acks on cycle g+1, and the next grant may happen at edge g+3.
  logic [31:0] exp_mem [0:8191];
  int          cyc = 0;
  int          g = -10;
  bit          last_d = 1'b1;
  bit          t_d = 1'b0;
  logic [3:0]  t_we = '0;
  logic [12:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] exp_rd = '0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] a;
    bit          w;
    if (rst) begin
      g      = -10;
      last_d = 1'b1;
      cyc    = 0;
    end else begin
      cyc++;
      if (cyc == g + 1) begin
        if (t_we == 4'h0) exp_rd = exp_mem[t_addr];
        for (int b = 0; b < 4; b++)
          if (t_we[b]) exp_mem[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
      end
      if (cyc > g + 2 && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (i_req && d_req) ? !last_d : d_req;
`else
        w = d_req;
`endif
        a       = w ? d_addr : i_addr;
        g       = cyc;
        t_d     = w;
        last_d  = w;
        t_addr  = a[14:2];
        t_we    = w ? d_we : 4'h0;
        t_wdata = d_wdata;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    bit acc, rsp;
    if (!rst) begin
      acc = (cyc == g);
      rsp = (cyc == g + 1);
      chk("i_ack", {31'b0, i_ack}, {31'b0, rsp && !t_d});
      chk("d_ack", {31'b0, d_ack}, {31'b0, rsp && t_d});
      chk("m_rd", {31'b0, m_rd}, {31'b0, !(acc && t_we == 4'h0)});
      chk("m_we", {28'b0, m_we}, acc ? {28'b0, t_we} : 32'h0);
      if (acc) chk("m_addr", {19'b0, m_addr}, {19'b0, t_addr});
      if (acc && t_we != 4'h0) chk("m_data", m_data, t_wdata);
      if (rsp && !t_d) chk("i_rdata", i_rdata, exp_rd);
      if (rsp && t_d && t_we == 4'h0) chk("d_rdata", d_rdata, exp_rd);
    end
  end

  task automatic do_fetch(input logic [31:0] a, output logic [31:0] rd,
                          output int lat);
    bit got = 1'b0;
    lat = 0;
    rd = '0;
    i_addr = a;
    i_req = 1'b1;
    for (int n = 1; n <= 10; n++)
      if (!got) begin
        @(negedge clk);
        if (i_ack) begin got = 1'b1; lat = n; rd = i_rdata; end
      end
    i_req = 1'b0;
    chk("fetch_done", {31'b0, got}, 32'h1);
    @(negedge clk);
  endtask

  task automatic do_data(input logic [3:0] we, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output int lat);
    bit got = 1'b0;
    lat = 0;
    rd = '0;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    for (int n = 1; n <= 10; n++)
      if (!got) begin
        @(negedge clk);
        if (d_ack) begin got = 1'b1; lat = n; rd = d_rdata; end
      end
    d_req = 1'b0;
    chk("data_done", {31'b0, got}, 32'h1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          na;
    int          extra;
    int          off;
    logic [3:0]  ord;
    logic [3:0]  exp_ord;

    for (int k = 0; k < 8192; k++) begin
      mem[k]     = $urandom;
      exp_mem[k] = mem[k];
    end
    mem[1]  = 32'h0BAD_F00D; exp_mem[1]  = 32'h0BAD_F00D;
    mem[4]  = 32'hDEAD_BEEF; exp_mem[4]  = 32'hDEAD_BEEF;
    mem[8]  = 32'h1122_3344; exp_mem[8]  = 32'h1122_3344;
    mem[12] = 32'h5555_5555; exp_mem[12] = 32'h5555_5555;

    repeat (3) @(negedge clk);
    chk("rst_m_rd", {31'b0, m_rd}, 32'h1);
    chk("rst_m_we", {28'b0, m_we}, 32'h0);
    chk("rst_m_addr", {19'b0, m_addr}, 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_acks", {30'b0, i_ack, d_ack}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // simultaneous requests held for four transactions
    i_addr = 32'h10; d_addr = 32'h4; d_we = 4'h0;
    i_req = 1'b1; d_req = 1'b1;
    na = 0; ord = '0;
    for (int n = 1; n <= 20; n++)
      if (na < 4) begin
        @(negedge clk);
        if (i_ack) begin ord[na] = 1'b0; na++; end
        else if (d_ack) begin ord[na] = 1'b1; na++; end
        if (na == 4) begin i_req = 1'b0; d_req = 1'b0; end
      end
    i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = 4'b1010;
`else
    exp_ord = 4'b1111;
`endif
    chk("tie_count", na, 4);
    chk("tie_order", {28'b0, ord}, {28'b0, exp_ord});
    @(negedge clk);

    do_fetch(32'h0000_0010, rd, lat);
    chk("fetch_data", rd, 32'hDEAD_BEEF);
    chk("fetch_lat", lat, 2);

    do_data(4'b0010, 32'h20, 32'h0000_AB00, rd, lat);
    chk("wr_lat", lat, 2);
    do_data(4'b0000, 32'h20, 32'h0, rd, lat);
    chk("byte_merge", rd, 32'h1122_AB44);

    do_data(4'b0000, 32'h0000_8004, 32'h0, rd, lat);
    chk("addr_wrap", rd, 32'h0BAD_F00D);

    // reset during the ACCESS cycle of a write
    d_we = 4'hF; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
    @(negedge clk);
    chk("acc_m_we", {28'b0, m_we}, 32'hF);
    rst = 1'b1;
    #1;
    chk("rst_acc_m_we", {28'b0, m_we}, 32'h0);
    chk("rst_acc_m_rd", {31'b0, m_rd}, 32'h1);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_no_ack", {31'b0, d_ack}, 32'h0);
    end
    do_data(4'b0000, 32'h30, 32'h0, rd, lat);
    chk("rst_no_write", rd, 32'h5555_5555);
    do_data(4'hF, 32'h30, 32'hCAFE_F00D, rd, lat);
    do_data(4'b0000, 32'h30, 32'h0, rd, lat);
    chk("reissue_write", rd, 32'hCAFE_F00D);

    // late drop: req stays high through the following IDLE edge
    i_addr = 32'h10; i_req = 1'b1;
    na = 0;
    for (int n = 1; n <= 10; n++)
      if (na == 0) begin
        @(negedge clk);
        if (i_ack) na = 1;
      end
    chk("late_first_ack", na, 1);
    extra = 0; off = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) i_req = 1'b0;
      if (i_ack) begin
        extra++;
        if (off == 0) off = k;
      end
    end
    i_req = 1'b0;
    chk("late_extra_acks", extra, 1);
    chk("late_offset", off, 3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (i_req && i_ack) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 1) == 1) begin
        i_addr = $urandom & 32'hFFFF_807F;
        i_req = 1'b1;
      end
      if (d_req && d_ack) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 1) == 1) begin
        d_addr  = $urandom & 32'hFFFF_807F;
        d_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
        d_wdata = $urandom;
        d_req   = 1'b1;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port arbiter that shares the single-port 8K x 32 block RAM between the CPU instruction-fetch port and the load/store data port of the OTTER multicycle core. It accepts one outstanding request per port and sequences each granted request into a read or a byte-masked write on the RAM. It returns a one-cycle acknowledge with read data to the winning requester. It sits between the core's memory interface and the RAM instance, and is the only driver of the RAM's control pins.

## Interface
- RAM_ADDR_WIDTH, 13, word-address width of the RAM (2**13 words).
- RAM_BUS_WIDTH, 32, data width of the RAM.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_rdata  out  RAM_BUS_WIDTH  fetched word; valid only while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  4  byte write enables; 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  RAM_BUS_WIDTH  write data, byte lanes per d_we.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  RAM_BUS_WIDTH  read word; valid only while d_ack=1 and d_we=0.
- m_rd  out  1  RAM read enable, active-low.
- m_we  out  4  RAM byte write enables.
- m_addr  out  RAM_ADDR_WIDTH  RAM word address.
- m_data  out  RAM_BUS_WIDTH  RAM write data.
- m_out  in  RAM_BUS_WIDTH  RAM registered read data (1-cycle latency).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if either req=1, select winner; latch owner, we (0 for fetch), addr[RAM_ADDR_WIDTH+1:2], wdata into registers; go ACCESS. Otherwise stay.
- ACCESS: drive m_addr/m_data from latched values. Read: m_rd=0, m_we=0. Write: m_rd=1, m_we=latched we. Always go RESP.
- RESP: m_rd=1, m_we=0; assert owner's ack; go IDLE.
- i_rdata and d_rdata are combinational copies of m_out; m_out holds because m_rd=1 in RESP.
- Address bits [1:0] and above RAM_ADDR_WIDTH+1 are ignored; out-of-range addresses wrap.
- Requester must drop req in the cycle after ack; a req still high in IDLE is a new request.
- Request fields are sampled only in IDLE; changes during ACCESS/RESP have no effect.
- A losing requester stays pending and is served next IDLE.
- Reset (any state): state=IDLE, i_ack=d_ack=0, m_rd=1, m_we=0, m_addr=0, m_data=0, owner/priority register=DATA_LAST; in-flight transaction dropped, no ack, requester re-issues.

## Timing
- req high at edge k (IDLE) -> ACCESS in cycle k..k+1, ack high in cycle k+1..k+2; 3 cycles/transaction, 2 cycles req-to-ack.
- Write committed at the edge ending ACCESS, before ack.
- Back-to-back: max one transaction per 3 cycles; alternating ports under contention -> each served every 6 cycles.
- Both acks never high in the same cycle; m_we nonzero only in ACCESS.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last; last-grant register reset to DATA, so first tie goes to fetch.
- Undefined: fixed priority, data port always wins ties; fetch is served only when d_req=0 in IDLE.

## Test plan
- Fetch only: i_addr=0x0000_0010 with mem[4]=0xDEADBEEF -> i_ack 2 cycles after grant, i_rdata=0xDEADBEEF, m_rd=0 only in ACCESS.
- Byte write then read: d_we=4'b0010, d_addr=0x20, d_wdata=0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
- Simultaneous i_req/d_req held 4 transactions: with ARB_ROUND_ROBIN_EN acks go I,D,I,D; without, D,D,D,D while d_req is held.
- Address wrap: d_addr=0x0000_8004 reads mem[1].
- Reset asserted in ACCESS of a write: no ack, m_we=0 immediately, state IDLE; re-issued request completes normally.
- Late drop: req held one extra cycle after ack -> second identical transaction served, no lost or duplicated ack otherwise.
